// File: rtl/display_arbiter_pkg.sv
// display_arbiter_pkg: framebuffer geometry, arbiter state encodings and the OLED-to-framebuffer address map
package display_arbiter_pkg;
   localparam int FB_WIDTH = 64;
   localparam int FB_HEIGHT = 32;
   localparam int FB_BYTES = FB_WIDTH * FB_HEIGHT / 8;
   localparam int FB_ADDR_W = $clog2(FB_BYTES);
   localparam int OLED_COLS = 128;
   localparam int OLED_X_SHIFT = $clog2(OLED_COLS / FB_WIDTH);
   localparam int PIXELS_PER_PAGE = 4;

   typedef enum logic [2:0] {
      ST_IDLE, ST_CPU_ACC, ST_CPU_ACK, ST_OLED_FETCH, ST_OLED_ACK, ST_CLEAR
   } state_t;

   typedef enum logic {GR_CPU, GR_OLED} grant_t;

   // Framebuffer byte holding CHIP-8 row k of an OLED page at a 2x-scaled column.
   function automatic logic [FB_ADDR_W-1:0] oled_fb_addr(input logic [5:0] page, input logic [6:0] col,
                                                       input logic [1:0] k);
      logic [7:0] x, y;
      x = 8'(col) >> OLED_X_SHIFT;
      y = 8'(page) * 8'(PIXELS_PER_PAGE) + 8'(k);
      return y * 8'(FB_WIDTH / 8) + x / 8'd8;
   endfunction
endpackage

// File: rtl/display_arbiter_fb_ram.sv
// fb_ram: 256x8 single-port framebuffer, synchronous write with a registered read
module fb_ram
   import display_arbiter_pkg::*;
(
   input  logic                 clk,
   input  logic                 we,
   input  logic [FB_ADDR_W-1:0] addr,
   input  logic [7:0]           wdata,
   output logic [7:0]           rdata
);
   logic [7:0] mem [FB_BYTES];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end
endmodule

// File: rtl/display_arbiter.sv
// display_arbiter: shares the CHIP-8 framebuffer between CPU accesses and OLED vertical-byte fetches
module display_arbiter
   import display_arbiter_pkg::*;
#(
   parameter bit CLEAR_ON_RESET = 1'b1,
   parameter int OLED_PAGES = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cpu_req,
   input  logic       cpu_we,
   input  logic       cpu_clr,
   input  logic [7:0] cpu_addr,
   input  logic [7:0] cpu_wdata,
   output logic [7:0] cpu_rdata,
   output logic       cpu_ack,
   input  logic       oled_read,
   input  logic [5:0] oled_row_idx,
   input  logic [6:0] oled_column_idx,
   output logic [7:0] oled_data,
   output logic       oled_ack
);
   localparam logic [6:0] PAGES = 7'(OLED_PAGES);

   state_t     state;
   grant_t     last_grant;
   logic [7:0] cnt, pix, ram_addr, ram_wdata, ram_rdata;
   logic [5:0] oled_page;
   logic [6:0] oled_col;
   logic       oled_pend, clr_cpu, cpu_rd, ram_we, cpu_v, oled_take, px;

   // A request still high in its own ack cycle is the one just served.
   assign cpu_v = cpu_req & ~cpu_ack;
   assign oled_take = oled_read & (~oled_pend | state == ST_OLED_ACK);
   assign px = ram_rdata[~oled_col[3:1]];

   always_comb begin
      ram_we = state == ST_CLEAR || (state == ST_CPU_ACC && cpu_we);
      ram_addr = state == ST_CLEAR ? cnt :
                 state == ST_OLED_FETCH ? oled_fb_addr(oled_page, oled_col, cnt[1:0]) : cpu_addr;
      ram_wdata = state == ST_CLEAR ? 8'h00 : cpu_wdata;
   end

   fb_ram u_ram (.clk, .we(ram_we), .addr(ram_addr), .wdata(ram_wdata), .rdata(ram_rdata));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
         last_grant <= GR_CPU;
         cnt <= '0;
         pix <= '0;
         cpu_ack <= 1'b0;
         oled_ack <= 1'b0;
         cpu_rdata <= '0;
         oled_data <= '0;
         oled_pend <= 1'b0;
         oled_page <= '0;
         oled_col <= '0;
         clr_cpu <= 1'b0;
         cpu_rd <= 1'b0;
      end else begin
         cpu_ack <= 1'b0;
         oled_ack <= 1'b0;
         oled_pend <= oled_take | (oled_pend & (state != ST_OLED_ACK));
         if (oled_take) begin
            oled_page <= oled_row_idx;
            oled_col <= oled_column_idx;
         end
         case (state)
            ST_IDLE:
               if (cpu_v && (!oled_pend || last_grant == GR_OLED)) begin
                  last_grant <= GR_CPU;
                  clr_cpu <= 1'b1;
                  cpu_rd <= ~cpu_we & ~cpu_clr;
                  cnt <= '0;
                  state <= cpu_clr ? ST_CLEAR : ST_CPU_ACC;
               end else if (oled_pend) begin
                  last_grant <= GR_OLED;
                  cnt <= '0;
                  pix <= '0;
                  state <= {1'b0, oled_page} >= PAGES ? ST_OLED_ACK : ST_OLED_FETCH;
               end
            ST_CPU_ACC: state <= ST_CPU_ACK;
            ST_CPU_ACK: begin
               cpu_ack <= 1'b1;
               if (cpu_rd) cpu_rdata <= ram_rdata;
               state <= ST_IDLE;
            end
            // Read data trails its address by one cycle; pixel k lands in bits 2k+1:2k after four shifts.
            ST_OLED_FETCH: begin
               cnt <= cnt + 8'd1;
               if (cnt != 8'd0) pix <= {{2{px}}, pix[7:2]};
               if (cnt == 8'd4) state <= ST_OLED_ACK;
            end
            ST_OLED_ACK: begin
               oled_ack <= 1'b1;
               oled_data <= pix;
               state <= ST_IDLE;
            end
            ST_CLEAR: begin
               cnt <= cnt + 8'd1;
               if (cnt == 8'hFF) state <= clr_cpu ? ST_CPU_ACK : ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Owns the CHIP-8 64x32 monochrome framebuffer: 256 bytes, row-major, 8 horizontal pixels per byte, MSB = leftmost pixel.
- Shares the framebuffer between two requesters: the CPU (byte read/write/clear) and the OLED driver's pixel-fetch interface (read / row_idx / column_idx / data / ack).
- Turns each OLED byte request (one page, one column of a 128x64 panel, 2x scaled) into four framebuffer reads and assembles the vertical byte.
- Replaces the test-pattern generator on the OLED read port.

Parameters:
- CLEAR_ON_RESET, 1, when 1 the block runs a full framebuffer clear after reset.
- OLED_PAGES, 8, number of valid OLED pages; row_idx values >= this are answered with 0x00.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; ignored when cpu_clr = 1.
- cpu_clr  in  1  with cpu_req: clear the whole framebuffer.
- cpu_addr  in  8  byte address, y*8 + x/8.
- cpu_wdata  in  8  write data.
- cpu_rdata  out  8  read data; valid while cpu_ack = 1.
- cpu_ack  out  1  one-cycle completion pulse.
- oled_read  in  1  one-cycle pulse requesting one OLED byte.
- oled_row_idx  in  6  OLED page index.
- oled_column_idx  in  7  OLED column, 0..127.
- oled_data  out  8  OLED byte; bit 0 = top pixel of the page.
- oled_ack  out  1  one-cycle pulse, oled_data valid.

Behaviour:
- Reset values: cpu_ack = 0, oled_ack = 0, cpu_rdata = 0, oled_data = 0. OLED pending flag cleared. last_grant = CPU.
- State after reset: CLEAR if CLEAR_ON_RESET = 1, else IDLE. RAM contents are not reset by reset itself.
- Reset mid-operation aborts any access. No ack is issued for it.
- OLED request capture: oled_read sets the pending flag, and row/column are latched, on any cycle including while busy. A second pulse while pending is a protocol violation and is ignored.
- States: IDLE, CPU_ACC, CPU_ACK, OLED_FETCH (k = 0..3), OLED_ACK, CLEAR.
- Arbitration is evaluated in IDLE only. Accesses are never preempted.
  - Both pending: grant the requester not in last_grant, then update last_grant.
  - One pending: grant it.
  - CLEAR blocks both requesters. Their requests are held and served afterwards.
- CPU read/write: cpu_req sampled in IDLE at edge n.
  - RAM access at edge n+1.
  - cpu_ack high after edge n+2 for one cycle; cpu_rdata is RAM data for a read, unchanged for a write.
- CPU clear: cpu_req & cpu_clr sampled at edge n.
  - Writes 0x00 to addresses 0..255 at edges n+1..n+256.
  - cpu_ack high after edge n+257.
- Reset clear: same 256-write sequence, no ack. Returns to IDLE.
- OLED fetch: grant at edge n, page p, column c.
  - x = c>>1; y = 4p+k; address = y*8 + x[5:3]; bit = 7 - x[2:0].
  - Four addresses issued at edges n+1..n+4. RAM has 1-cycle synchronous read.
  - Pixel k is written to oled_data bits 2k and 2k+1.
  - oled_ack high after edge n+6 for one cycle.
- OLED out-of-range: if p >= OLED_PAGES, no RAM access; oled_data = 0x00 and oled_ack high after edge n+1.
- Width rules: all address arithmetic is 8-bit and cannot wrap for legal inputs (p < 8 ⇒ y < 32).

Decomposition:
- Shared include/package chip8_display_defs:
  - FB_WIDTH = 64, FB_HEIGHT = 32, FB_BYTES = 256, FB_ADDR_W = 8.
  - OLED_COLS = 128, PIXELS_PER_PAGE = 4 (CHIP-8 rows per OLED page).
  - State encodings.
- Sub-module fb_ram: 256x8 single-port, synchronous write, 1-cycle registered read; infers one BRAM.

Test Plan:
- Reset with CLEAR_ON_RESET = 1 -> no ack for 256+ cycles; then CPU read of 0xFF returns 0x00, cpu_ack exactly 2 edges after grant.
- CPU write 0x00 <= 0x80, then OLED read page 0: column 0 -> 0x03, column 1 -> 0x03, column 2 -> 0x00; each oled_ack 6 edges after grant.
- CPU writes 0x08 <= 0xFF and 0x18 <= 0x01, then OLED read page 0, column 14 -> 0xCC (pixels y = 1 and y = 3 at x = 7).
- cpu_req and oled_read in the same cycle after reset -> CPU served first, then OLED; repeated simultaneous requests alternate grants, and neither requester waits more than one foreign access.
- OLED read with row_idx = 9 -> oled_data 0x00, ack 1 edge after grant, no RAM address activity.
- CPU clear issued, OLED read pulsed during it -> OLED ack follows cpu_ack (edge n+257) and returns 0x00; assert reset mid-fetch -> no oled_ack, clear restarts.
